// File: rtl/bus_ram_responder.sv
// ============================================================================
// Module   : bus_ram_responder
// Purpose  : Byte-wide bus responder providing the text/font RAM. It decodes
//            its address window, inserts WAIT_STATES wait cycles after the
//            access is sampled, and completes every access with a single-cycle
//            ack pulse.
// Ports    : i_clk, i_reset (sync, active-high)
//            i_addr[15:0], i_dat[7:0], i_cs, i_we   - master request
//            o_dat[7:0], o_ack                      - response
//            i_wprot, o_wprot_hit                   - only when the macro
//                                                     BUS_RAM_RESPONDER_WRPROT_EN
//                                                     is defined
// Option   : BUS_RAM_RESPONDER_WRPROT_EN adds write protection. A protected
//            write is still acked but leaves RAM unchanged, and o_wprot_hit
//            pulses together with that ack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_ram_responder #(
    parameter logic [15:0] BASE        = 16'h0000,
    parameter int          ADDR_BITS   = 12,
    parameter int          WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_dat,
    output logic [7:0]  o_dat,
    input  logic        i_cs,
    input  logic        i_we,
    output logic        o_ack
`ifdef BUS_RAM_RESPONDER_WRPROT_EN
    ,
    input  logic        i_wprot,
    output logic        o_wprot_hit
`endif
);

    localparam int         DEPTH       = 1 << ADDR_BITS;
    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                 r_state_q, w_state_d;
    logic [3:0]             r_cnt_q,   w_cnt_d;
    logic [ADDR_BITS-1:0]   r_addr_q,  w_addr_d;
    logic                   r_we_q,    w_we_d;
    logic [7:0]             r_wdat_q,  w_wdat_d;
    logic [7:0]             r_dat_q;
    logic                   w_hit;
    logic                   w_commit;
    logic                   w_wprot;

    logic [7:0]             r_mem [0:DEPTH-1];

`ifdef BUS_RAM_RESPONDER_WRPROT_EN
    logic                   r_wp_q;
    assign w_wprot     = i_wprot;
    assign o_wprot_hit = (r_state_q == S_ACK) && r_we_q && r_wp_q;
`else
    assign w_wprot     = 1'b0;
`endif

    // Only the bits above the RAM index take part in the window compare.
    assign w_hit = i_cs && (i_addr[15:ADDR_BITS] == BASE[15:ADDR_BITS]);

    assign o_ack = (r_state_q == S_ACK);
    assign o_dat = r_dat_q;

    // w_commit marks the edge that enters ACK; the RAM is accessed exactly
    // there, using w_addr_d so the zero-wait path sees the fresh bus address.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_addr_d  = r_addr_q;
        w_we_d    = r_we_q;
        w_wdat_d  = r_wdat_q;
        w_commit  = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (w_hit) begin
                    w_addr_d = i_addr[ADDR_BITS-1:0];
                    w_we_d   = i_we;
                    w_wdat_d = i_dat;
                    w_cnt_d  = C_WAIT_LOAD;
                    if (C_WAIT_LOAD == 4'd0) begin
                        w_state_d = S_ACK;
                        w_commit  = 1'b1;
                    end else begin
                        w_state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!i_cs) begin
                    // Master withdrew the request: drop it silently.
                    w_state_d = S_IDLE;
                    w_cnt_d   = 4'd0;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                    if (r_cnt_q == 4'd1) begin
                        w_state_d = S_ACK;
                        w_commit  = 1'b1;
                    end
                end
            end
            S_ACK: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= 4'd0;
            r_addr_q  <= '0;
            r_we_q    <= 1'b0;
            r_wdat_q  <= 8'h00;
            r_dat_q   <= 8'h00;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_addr_q  <= w_addr_d;
            r_we_q    <= w_we_d;
            r_wdat_q  <= w_wdat_d;
            // o_dat only ever changes on a read ack.
            if (w_commit && !w_we_d) begin
                r_dat_q <= r_mem[w_addr_d];
            end
        end
    end

`ifdef BUS_RAM_RESPONDER_WRPROT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wp_q <= 1'b0;
        end else if (w_commit) begin
            r_wp_q <= i_wprot;
        end
    end
`endif

    // Contents are not reset; reset only blocks a write caught mid-access.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_commit && w_we_d && !w_wprot) begin
            r_mem[w_addr_d] <= w_wdat_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_ram_responder.sv
// ============================================================================
// Module   : tb_bus_ram_responder
// Purpose  : Self-checking bench for bus_ram_responder. Two instances share
//            one bus: A (BASE 16'h0000, one wait state) and B (BASE 16'h1000,
//            zero wait states). A cycle-level behavioural model predicts
//            ack, read data and the write-protect pulse of both instances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_ram_responder;

    localparam int WS [2]   = '{1, 0};
    localparam int BASES [2] = '{'h0000, 'h1000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  din = 8'h00;
    logic        cs = 1'b1;
    logic        we = 1'b0;
    logic        wprot = 1'b0;

    logic [7:0]  dat_a, dat_b;
    logic        ack_a, ack_b;
    logic [1:0]  ack_v;
    logic [7:0]  dat_v [2];
    logic [1:0]  wh_v;

`ifdef BUS_RAM_RESPONDER_WRPROT_EN
    logic        whit_a, whit_b;
    assign wh_v = {whit_b, whit_a};
`else
    assign wh_v = 2'b00;
`endif

    assign ack_v    = {ack_b, ack_a};
    assign dat_v[0] = dat_a;
    assign dat_v[1] = dat_b;

    always #5 clk = ~clk;

    bus_ram_responder #(.BASE(16'h0000), .ADDR_BITS(12), .WAIT_STATES(1)) u_dut_a (
        .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_dat(din), .o_dat(dat_a),
        .i_cs(cs), .i_we(we), .o_ack(ack_a)
`ifdef BUS_RAM_RESPONDER_WRPROT_EN
        , .i_wprot(wprot), .o_wprot_hit(whit_a)
`endif
    );

    bus_ram_responder #(.BASE(16'h1000), .ADDR_BITS(12), .WAIT_STATES(0)) u_dut_b (
        .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_dat(din), .o_dat(dat_b),
        .i_cs(cs), .i_we(we), .o_ack(ack_b)
`ifdef BUS_RAM_RESPONDER_WRPROT_EN
        , .i_wprot(wprot), .o_wprot_hit(whit_b)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------
    // Behavioural model: an access sampled at the end of cycle k acks in
    // cycle k+1+WS unless cs is seen low before then; the ack cycle itself
    // ignores the bus. RAM contents start unknown.
    // ------------------------------------------------------------------
    int         cyc = 0;
    logic [7:0] mem   [2][4096];
    bit         known [2][4096];
    bit         busy [2], in_ack [2], p_we [2];
    int         deadline [2];
    logic [11:0] p_a [2];
    logic [7:0] p_d [2];
    bit         exp_ack [2], exp_wh [2], exp_known [2];
    logic [7:0] exp_dat [2];

    task automatic commit(input int i, input bit wp);
        busy[i]    = 1'b0;
        in_ack[i]  = 1'b1;
        exp_ack[i] = 1'b1;
        if (p_we[i]) begin
            if (wp) exp_wh[i] = 1'b1;
            else begin
                mem[i][p_a[i]]   = p_d[i];
                known[i][p_a[i]] = 1'b1;
            end
        end else begin
            exp_dat[i]   = mem[i][p_a[i]];
            exp_known[i] = known[i][p_a[i]];
        end
    endtask

    task automatic model_step();
        int  k;
        bit  hit;
        bit  wp;
        k = cyc;
        cyc++;
`ifdef BUS_RAM_RESPONDER_WRPROT_EN
        wp = wprot;
`else
        wp = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            exp_ack[i] = 1'b0;
            exp_wh[i]  = 1'b0;
            hit = cs && ((int'(addr) >> 12) == (BASES[i] >> 12));
            if (rst) begin
                busy[i]      = 1'b0;
                in_ack[i]    = 1'b0;
                exp_dat[i]   = 8'h00;
                exp_known[i] = 1'b1;
            end else if (in_ack[i]) begin
                in_ack[i] = 1'b0;
            end else if (!busy[i]) begin
                if (hit) begin
                    p_a[i]      = addr[11:0];
                    p_we[i]     = we;
                    p_d[i]      = din;
                    busy[i]     = 1'b1;
                    deadline[i] = k + WS[i];
                    if (WS[i] == 0) commit(i, wp);
                end
            end else begin
                if (!cs) busy[i] = 1'b0;
                else if (k == deadline[i]) commit(i, wp);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            busy[i] = 0; in_ack[i] = 0; exp_ack[i] = 0; exp_wh[i] = 0;
            exp_known[i] = 0; exp_dat[i] = 8'h00;
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %0h, expected %0h",
                     name, inst, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                for (int i = 0; i < 2; i++) begin
                    chk("model_ack", i, 32'(ack_v[i]), 32'(exp_ack[i]));
                    if (exp_known[i]) chk("model_dat", i, 32'(dat_v[i]), 32'(exp_dat[i]));
                    chk("model_wprot_hit", i, 32'(wh_v[i]), 32'(exp_wh[i]));
                end
            end
        end
    end

    // Drive a request and wait for the selected instance to ack. Returns the
    // number of falling edges waited; from a fresh start in an idle cycle, or
    // right after a previous ack with cs held, this is WAIT_STATES+2.
    task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d,
                          input bit hold, input int inst, output int lat);
        bit got;
        addr = a; we = w; din = d; cs = 1'b1;
        lat = 0; got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            lat++;
            got = ack_v[inst];
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout inst%0d addr %0h: no ack within 40 cycles", inst, a);
        end
        if (!hold) cs = 1'b0;
    endtask

    task automatic idle(input int n);
        cs = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic count_acks(input int n, output int c0, output int c1);
        c0 = 0; c1 = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            c0 += int'(ack_v[0]);
            c1 += int'(ack_v[1]);
        end
    endtask

    initial begin
        int lat, c0, c1;
        logic [7:0] pre [4];
        pre[0] = 8'h10; pre[1] = 8'h21; pre[2] = 8'h32; pre[3] = 8'h43;

        // Reset held with cs asserted on a hit address.
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("reset_ack", 0, 32'(ack_a), 32'h0);
            chk("reset_dat", 0, 32'(dat_a), 32'h0);
            chk("reset_dat", 1, 32'(dat_b), 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        we = 1'b1;
        access(16'h0000, 1'b1, 8'h00, 1'b0, 0, lat);
        chk("post_reset_latency", 0, 32'(lat), 32'd3);
        idle(2);

        // Write then read with one wait state.
        access(16'h0123, 1'b1, 8'hA5, 1'b0, 0, lat);
        chk("write_latency", 0, 32'(lat), 32'd3);
        idle(1);
        access(16'h0123, 1'b0, 8'h00, 1'b0, 0, lat);
        chk("read_latency", 0, 32'(lat), 32'd3);
        chk("read_dat", 0, 32'(dat_a), 32'hA5);
        idle(3);
        chk("dat_hold", 0, 32'(dat_a), 32'hA5);
        access(16'h0200, 1'b1, 8'h99, 1'b0, 0, lat);
        chk("dat_hold_after_write", 0, 32'(dat_a), 32'hA5);
        idle(1);

        // Abort during the wait cycle.
        access(16'h0040, 1'b1, 8'h77, 1'b0, 0, lat);
        idle(1);
        addr = 16'h0040; we = 1'b1; din = 8'h3C; cs = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0;
        count_acks(6, c0, c1);
        chk("abort_no_ack", 0, 32'(c0), 32'd0);
        idle(1);
        access(16'h0040, 1'b0, 8'h00, 1'b0, 0, lat);
        chk("abort_no_write", 0, 32'(dat_a), 32'h77);
        idle(1);

        // Window decode.
        addr = 16'h2000; we = 1'b0; cs = 1'b1;
        count_acks(10, c0, c1);
        chk("miss_no_ack", 0, 32'(c0), 32'd0);
        chk("miss_no_ack", 1, 32'(c1), 32'd0);
        idle(1);
        access(16'h0FFF, 1'b1, 8'h5A, 1'b0, 0, lat);
        chk("top_of_window", 0, 32'(lat), 32'd3);
        idle(1);
        access(16'h1FFF, 1'b1, 8'hC3, 1'b0, 1, lat);
        chk("top_of_window", 1, 32'(lat), 32'd2);
        idle(1);
        access(16'h1FFF, 1'b0, 8'h00, 1'b0, 1, lat);
        chk("top_read", 1, 32'(dat_b), 32'hC3);
        idle(1);
        access(16'h0FFF, 1'b0, 8'h00, 1'b0, 0, lat);
        chk("top_read", 0, 32'(dat_a), 32'h5A);
        idle(1);

        // Back-to-back reads on the zero-wait instance.
        for (int j = 0; j < 4; j++) begin
            access(16'h1000 + 16'(j), 1'b1, pre[j], 1'b0, 1, lat);
            idle(1);
        end
        for (int j = 0; j < 4; j++) begin
            access(16'h1000 + 16'(j), 1'b0, 8'h00, 1'b1, 1, lat);
            chk("b2b_interval", 1, 32'(lat), 32'd2);
            chk("b2b_dat", 1, 32'(dat_b), 32'(pre[j]));
        end
        idle(2);

        // Reset in the middle of a write.
        access(16'h0050, 1'b1, 8'h22, 1'b0, 0, lat);
        idle(1);
        addr = 16'h0050; we = 1'b1; din = 8'hEE; cs = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cs = 1'b0;
        @(negedge clk);
        chk("midreset_dat", 0, 32'(dat_a), 32'h0);
        chk("midreset_ack", 0, 32'(ack_a), 32'h0);
        idle(1);
        access(16'h0050, 1'b0, 8'h00, 1'b0, 0, lat);
        chk("midreset_write_dropped", 0, 32'(dat_a), 32'h22);
        idle(1);

`ifdef BUS_RAM_RESPONDER_WRPROT_EN
        access(16'h0010, 1'b1, 8'h11, 1'b0, 0, lat);
        idle(1);
        wprot = 1'b1;
        access(16'h0010, 1'b1, 8'hFF, 1'b0, 0, lat);
        chk("wprot_hit", 0, 32'(whit_a), 32'h1);
        idle(1);
        wprot = 1'b0;
        access(16'h0010, 1'b0, 8'h00, 1'b0, 0, lat);
        chk("wprot_unchanged", 0, 32'(dat_a), 32'h11);
        idle(1);
`endif

        // Randomised bus traffic; inputs change with probability 1/3.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(99) == 0);
            if ($urandom_range(2) == 0) begin
                case ($urandom_range(5))
                    0: addr = 16'h0000 | 16'($urandom_range(15));
                    1: addr = 16'h0FF0 | 16'($urandom_range(15));
                    2: addr = 16'h1000 | 16'($urandom_range(15));
                    3: addr = 16'h1FF0 | 16'($urandom_range(15));
                    4: addr = 16'h2000 | 16'($urandom_range(15));
                    default: addr = 16'($urandom);
                endcase
                we    = 1'($urandom);
                din   = 8'($urandom);
                wprot = ($urandom_range(3) == 0);
            end
            if ($urandom_range(2) == 0) cs = ($urandom_range(3) != 0);
        end
        rst = 1'b0; cs = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
